ysyx_23060096_wbu: RTL and testbench

- Writeback unit of the NPC core; sits directly upstream of the register file write port.
- Accepts completed instructions from the EXU (ALU results) and the LSU (load data) over valid/ready handshakes, and arbitrates between them.
- Sign/zero-extends load data, then drives one registered write (waddr/wdata/w_en) per cycle plus a commit pulse for difftest.
- Exposes the in-flight write as a forwarding source.

---
 rtl/ysyx_23060096_pkg.sv | 10 +
 rtl/ysyx_23060096_load_ext.sv | 21 ++
 rtl/ysyx_23060096_wbu.sv | 87 ++++++++
 tb/tb_ysyx_23060096_wbu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060096_pkg.sv
// ysyx_23060096_pkg: shared widths and load funct3 encodings for the writeback path
package ysyx_23060096_pkg;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;
    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
endpackage

// File: rtl/ysyx_23060096_load_ext.sv
// ysyx_23060096_load_ext: selects and sign/zero-extends the loaded byte or half
module ysyx_23060096_load_ext
    import ysyx_23060096_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] ext
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{addr_lo, 3'b000} +: 8];
    // addr_lo[0] is ignored for halves: misalignment is trapped before the LSU
    assign h = rdata[{addr_lo[1], 4'b0000} +: 16];
    assign ext = (funct3 == F3_LB)  ? {{(DATA_WIDTH-8){b[7]}}, b}   :
                 (funct3 == F3_LH)  ? {{(DATA_WIDTH-16){h[15]}}, h} :
                 (funct3 == F3_LBU) ? {{(DATA_WIDTH-8){1'b0}}, b}   :
                 (funct3 == F3_LHU) ? {{(DATA_WIDTH-16){1'b0}}, h}  : rdata;
endmodule

// File: rtl/ysyx_23060096_wbu.sv
// ysyx_23060096_wbu: arbitrates EXU/LSU results into one registered regfile write and retire pulse
module ysyx_23060096_wbu
    import ysyx_23060096_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  exu_valid,
    output logic                  exu_ready,
    input  logic [ADDR_WIDTH-1:0] exu_rd,
    input  logic                  exu_wen,
    input  logic [DATA_WIDTH-1:0] exu_result,
    input  logic [DATA_WIDTH-1:0] exu_pc,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    input  logic [1:0]            lsu_addr_lo,
    input  logic [2:0]            lsu_funct3,
    input  logic [DATA_WIDTH-1:0] lsu_pc,
    input  logic                  wb_hold,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  w_en,
    output logic                  commit_valid,
    output logic [DATA_WIDTH-1:0] commit_pc,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data
);
    logic                  rr_q, rr_d;
    logic                  wb_valid_q, wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] data_q, data_d, pc_q, pc_d, lsu_data;
    logic                  grant_exu, grant_lsu;

    ysyx_23060096_load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .rdata  (lsu_rdata),
        .addr_lo(lsu_addr_lo),
        .funct3 (lsu_funct3),
        .ext    (lsu_data)
    );

    // rr_q=0 favours the LSU when both sources contend
    assign grant_lsu = lsu_valid && (!exu_valid || !rr_q);
    assign grant_exu = exu_valid && (!lsu_valid || rr_q);
    assign lsu_ready = grant_lsu && !wb_hold && rstn;
    assign exu_ready = grant_exu && !wb_hold && rstn;

    always_comb begin
        rd_d   = lsu_ready ? lsu_rd   : exu_ready ? exu_rd     : rd_q;
        wen_d  = lsu_ready ? lsu_wen  : exu_ready ? exu_wen    : wen_q;
        data_d = lsu_ready ? lsu_data : exu_ready ? exu_result : data_q;
        pc_d   = lsu_ready ? lsu_pc   : exu_ready ? exu_pc     : pc_q;
        rr_d   = (exu_valid && lsu_valid && !wb_hold) ? !rr_q : rr_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wen_q      <= 1'b0;
            rd_q       <= '0;
            data_q     <= '0;
            pc_q       <= '0;
        end else begin
            rr_q       <= rr_d;
            wb_valid_q <= lsu_ready || exu_ready;
            wen_q      <= wen_d;
            rd_q       <= rd_d;
            data_q     <= data_d;
            pc_q       <= pc_d;
        end
    end

    assign waddr        = rd_q;
    assign wdata        = data_q;
    assign w_en         = wb_valid_q && wen_q && (rd_q != '0);
    assign commit_valid = wb_valid_q;
    assign commit_pc    = pc_q;
    assign fwd_valid    = w_en;
    assign fwd_rd       = rd_q;
    assign fwd_data     = data_q;
endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// tb_ysyx_23060096_wbu: directed vectors for arbitration, load extension, hold and async reset
module tb_ysyx_23060096_wbu;
    logic        clk, rstn;
    logic        exu_valid, exu_ready, exu_wen;
    logic [4:0]  exu_rd;
    logic [31:0] exu_result, exu_pc;
    logic        lsu_valid, lsu_ready, lsu_wen;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_rdata, lsu_pc;
    logic [1:0]  lsu_addr_lo;
    logic [2:0]  lsu_funct3;
    logic        wb_hold;
    logic [4:0]  waddr, fwd_rd;
    logic [31:0] wdata, commit_pc, fwd_data;
    logic        w_en, commit_valid, fwd_valid;
    int          tests = 0;
    int          fails = 0;

    ysyx_23060096_wbu dut (
        .clk(clk), .rstn(rstn),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_wen(exu_wen),
        .exu_result(exu_result), .exu_pc(exu_pc),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_wen(lsu_wen),
        .lsu_rdata(lsu_rdata), .lsu_addr_lo(lsu_addr_lo), .lsu_funct3(lsu_funct3), .lsu_pc(lsu_pc),
        .wb_hold(wb_hold), .waddr(waddr), .wdata(wdata), .w_en(w_en),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp, input string tag);
        lsu_valid = 1; lsu_wen = 1; lsu_rd = 5'd7; lsu_rdata = 32'h80FF_7F01;
        lsu_funct3 = f3; lsu_addr_lo = lo; lsu_pc = 32'h8000_0100;
        tick();
        lsu_valid = 0;
        check(tag, wdata, exp);
        check({tag, "_wen"}, w_en, 1);
    endtask

    initial begin
        rstn = 0; wb_hold = 0;
        exu_valid = 1; exu_rd = 0; exu_wen = 0; exu_result = 0; exu_pc = 0;
        lsu_valid = 1; lsu_rd = 0; lsu_wen = 0; lsu_rdata = 0; lsu_addr_lo = 0; lsu_funct3 = 0; lsu_pc = 0;
        #3;
        check("rst_exu_ready", exu_ready, 0);
        check("rst_lsu_ready", lsu_ready, 0);
        check("rst_w_en", w_en, 0);
        check("rst_commit", commit_valid, 0);
        check("rst_wdata", wdata, 0);
        check("rst_commit_pc", commit_pc, 0);
        tick();
        rstn = 1; exu_valid = 0; lsu_valid = 0;
        tick();

        exu_valid = 1; exu_rd = 5; exu_wen = 1; exu_result = 32'h1234_5678; exu_pc = 32'h8000_0000;
        #1 check("exu_ready", exu_ready, 1);
        tick();
        exu_valid = 0;
        check("exu_w_en", w_en, 1);
        check("exu_waddr", waddr, 5);
        check("exu_wdata", wdata, 32'h1234_5678);
        check("exu_commit", commit_valid, 1);
        check("exu_commit_pc", commit_pc, 32'h8000_0000);
        check("exu_fwd", {fwd_valid, fwd_rd, fwd_data[25:0]}, {1'b1, 5'd5, 26'h234_5678});
        tick();
        check("idle_w_en", w_en, 0);
        check("idle_commit", commit_valid, 0);
        check("idle_wdata_kept", wdata, 32'h1234_5678);

        load(3'd0, 2'd3, 32'hFFFF_FF80, "lb3");
        load(3'd4, 2'd1, 32'h0000_007F, "lbu1");
        load(3'd1, 2'd2, 32'hFFFF_80FF, "lh2");
        load(3'd5, 2'd0, 32'h0000_7F01, "lhu0");
        load(3'd2, 2'd1, 32'h80FF_7F01, "lw");
        load(3'd1, 2'd3, 32'hFFFF_80FF, "lh3");
        tick();

        exu_valid = 1; exu_rd = 1; exu_wen = 1; exu_result = 32'hE; exu_pc = 32'h10;
        lsu_valid = 1; lsu_rd = 2; lsu_wen = 1; lsu_funct3 = 3'd2; lsu_rdata = 32'hA; lsu_pc = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("cont_lsu_ready", lsu_ready, (i % 2 == 0) ? 1 : 0);
            check("cont_one_ready", exu_ready ^ lsu_ready, 1);
            tick();
            check("cont_commit", commit_valid, 1);
            check("cont_waddr", waddr, (i % 2 == 0) ? 2 : 1);
        end
        exu_valid = 0; lsu_valid = 0;
        tick();

        exu_valid = 1; exu_rd = 0; exu_wen = 1; exu_result = 32'h55;
        tick();
        exu_valid = 0;
        check("x0_commit", commit_valid, 1);
        check("x0_w_en", w_en, 0);
        lsu_valid = 1; lsu_rd = 3; lsu_wen = 0;
        tick();
        lsu_valid = 0;
        check("store_commit", commit_valid, 1);
        check("store_w_en", w_en, 0);
        tick();

        wb_hold = 1; exu_valid = 1; exu_rd = 9; exu_wen = 1; exu_result = 32'h99; exu_pc = 32'h90;
        for (int i = 0; i < 3; i++) begin
            #1 check("hold_ready", exu_ready, 0);
            tick();
            check("hold_commit", commit_valid, 0);
        end
        wb_hold = 0;
        #1 check("release_ready", exu_ready, 1);
        tick();
        exu_valid = 0;
        check("release_commit", commit_valid, 1);
        check("release_waddr", waddr, 9);
        check("release_pc", commit_pc, 32'h90);
        exu_valid = 1; exu_rd = 10; exu_result = 32'hAA;
        tick();
        wb_hold = 1;
        check("inflight_retire", {w_en, commit_valid, waddr}, {1'b1, 1'b1, 5'd10});
        tick();
        check("inflight_none", commit_valid, 0);
        wb_hold = 0; exu_valid = 0;
        tick();

        exu_valid = 1; exu_rd = 1; lsu_valid = 1; lsu_rd = 2; lsu_wen = 1;
        tick();
        exu_valid = 0; lsu_valid = 0;
        check("pre_rst_w_en", w_en, 1);
        check("pre_rst_waddr", waddr, 2);
        #2 rstn = 0;
        #1;
        check("arst_w_en", w_en, 0);
        check("arst_commit", commit_valid, 0);
        check("arst_waddr", waddr, 0);
        #1 rstn = 1;
        exu_valid = 1; lsu_valid = 1;
        #1;
        check("post_rst_lsu_ready", lsu_ready, 1);
        check("post_rst_exu_ready", exu_ready, 0);
        tick();
        exu_valid = 0; lsu_valid = 0;
        check("post_rst_waddr", waddr, 2);
        check("post_rst_commit", commit_valid, 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
